// File: rtl/store_drain_buffer_if.sv
`default_nettype none
// ===========================================================================
// store_drain_buffer_if : core store port plus memory drain port and status
// Revision: 1.0
// ===========================================================================
interface store_drain_buffer_if #(
  parameter int ERR_W = 8
);
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [2:0]       st_width;
  logic             stall;

  logic             mem_req;
  logic             mem_ready;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;

  logic             empty;
  logic             misaligned_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output st_valid, st_addr, st_data, st_width, mem_ready,
    input  stall, mem_req, mem_addr, mem_be, mem_wdata,
           empty, misaligned_err, err_count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_width, mem_ready,
    output stall, mem_req, mem_addr, mem_be, mem_wdata,
           empty, misaligned_err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/store_drain_buffer.sv
`default_nettype none
// ===========================================================================
// store_drain_buffer : lane-formats core stores into an in-order FIFO and
// drains them over req/ready. Optional macro STORE_COALESCE_EN merges a store
// into the youngest entry when it targets the same word.
// Revision: 1.0
// ===========================================================================
module store_drain_buffer #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  store_drain_buffer_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count;
  logic [AW-1:0]    wr_idx, rd_idx, tail_idx;
  logic             full;
  logic             push, pop, req;

  logic [29:0]      ent_addr_q [DEPTH];
  logic [3:0]       ent_be_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];

  logic             legal;
  logic [3:0]       fmt_be;
  logic [31:0]      fmt_data;
  logic             err_inc;
  logic             err_flag_q;
  logic [ERR_W-1:0] err_cnt_q;

  // Pointers carry an extra wrap bit so full and empty stay distinguishable.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == CNT_FULL);
  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign tail_idx = wr_idx - 1'b1;

  always_comb begin
    legal    = 1'b0;
    fmt_be   = 4'b0000;
    fmt_data = bus.st_data;
    case (bus.st_width)
      3'b000: begin
        legal    = 1'b1;
        fmt_be   = 4'b0001 << bus.st_addr[1:0];
        fmt_data = {4{bus.st_data[7:0]}};
      end
      3'b001: begin
        legal    = ~bus.st_addr[0];
        fmt_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_data = {2{bus.st_data[15:0]}};
      end
      3'b010: begin
        legal    = (bus.st_addr[1:0] == 2'b00);
        fmt_be   = 4'b1111;
        fmt_data = bus.st_data;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign pop     = req & bus.mem_ready;
  assign err_inc = bus.st_valid & ~legal & ~full;

`ifdef STORE_COALESCE_EN
  logic        merge;
  logic [31:0] merge_data;

  // A single-entry FIFO being accepted this cycle cannot absorb a merge.
  assign merge = bus.st_valid & legal & (count != '0)
               & (ent_addr_q[tail_idx] == bus.st_addr[31:2])
               & ~((count == CNT_ONE) & pop);
  assign push  = bus.st_valid & legal & ~merge & ~full;

  always_comb begin
    merge_data = ent_data_q[tail_idx];
    for (int b = 0; b < 4; b++) begin
      if (fmt_be[b]) begin
        merge_data[b*8 +: 8] = fmt_data[b*8 +: 8];
      end
    end
  end
`else
  assign push = bus.st_valid & legal & ~full;
`endif

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(i);
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ent_addr_q[i] <= '0;
          ent_be_q[i]   <= '0;
          ent_data_q[i] <= '0;
        end else if (push && (wr_idx == IDX)) begin
          ent_addr_q[i] <= bus.st_addr[31:2];
          ent_be_q[i]   <= fmt_be;
          ent_data_q[i] <= fmt_data;
        end
`ifdef STORE_COALESCE_EN
        else if (merge && (tail_idx == IDX)) begin
          ent_be_q[i]   <= ent_be_q[i] | fmt_be;
          ent_data_q[i] <= merge_data;
        end
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entering REQ on the push edge gives one-cycle latency from an empty FIFO.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_ptr_d != rd_ptr_q) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (pop && (wr_ptr_d == rd_ptr_d)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (err_inc) begin
      err_flag_q <= 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall          = full;
  assign bus.empty          = (count == '0);
  assign bus.mem_req        = req;
  assign bus.mem_addr       = req ? {ent_addr_q[rd_idx], 2'b00} : '0;
  assign bus.mem_be         = req ? ent_be_q[rd_idx] : '0;
  assign bus.mem_wdata      = req ? ent_data_q[rd_idx] : '0;
  assign bus.misaligned_err = err_flag_q;
  assign bus.err_count      = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_store_drain_buffer.sv
`default_nettype none
// ===========================================================================
// tb_store_drain_buffer : directed self-checking bench for store_drain_buffer
// Revision: 1.0
// ===========================================================================
module tb_store_drain_buffer;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  store_drain_buffer_if #(.ERR_W(8)) bus ();

  store_drain_buffer #(.DEPTH(4), .ERR_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1;
    bus.st_width = w;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  initial begin : main
    int          sent;
    int          popped;
    logic        prev_hold;
    logic        accept;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [3:0]  hold_be;
    logic [15:0] hw;

    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.st_width  = '0;
    bus.mem_ready = 1'b0;
    repeat (2) tick();

    chk("rst_req",    bus.mem_req, 0);
    chk("rst_empty",  bus.empty, 1);
    chk("rst_stall",  bus.stall, 0);
    chk("rst_be",     bus.mem_be, 0);
    chk("rst_addr",   bus.mem_addr, 0);
    chk("rst_wdata",  bus.mem_wdata, 0);
    chk("rst_err",    bus.misaligned_err, 0);
    chk("rst_errcnt", bus.err_count, 0);
    reset_n = 1'b1;
    tick();

    // SB to top byte lane, drained with ready held high
    bus.mem_ready = 1'b1;
    store(3'b000, 32'h0000_1003, 32'h0000_00AB);
    tick();
    bus.st_valid = 1'b0;
    chk("sb_req",   bus.mem_req, 1);
    chk("sb_addr",  bus.mem_addr, 32'h0000_1000);
    chk("sb_be",    bus.mem_be, 4'b1000);
    chk("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    tick();
    chk("sb_empty", bus.empty, 1);
    chk("sb_req_off", bus.mem_req, 0);

    // Fill to full with ready low, hold a fifth store, then drain
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(3'b010, 32'h100 + 32'(4*i), 32'hD0 + 32'(i));
      tick();
      if (i == 2) chk("fill_stall3", bus.stall, 0);
    end
    chk("fill_stall4", bus.stall, 1);
    store(3'b010, 32'h110, 32'hD4);
    tick();
    chk("full_stall_held", bus.stall, 1);
    chk("full_head_held",  bus.mem_addr, 32'h100);
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_addr",  bus.mem_addr, 32'h100 + 32'(4*k));
      chk("drain_wdata", bus.mem_wdata, 32'hD0 + 32'(k));
      chk("drain_be",    bus.mem_be, 4'b1111);
      tick();
      if (k == 0) chk("stall_drop", bus.stall, 0);
      if (k == 1) bus.st_valid = 1'b0;
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_req",   bus.mem_req, 0);

    // Illegal stores are dropped and counted
    store(3'b010, 32'h0000_2002, 32'h1234_5678);
    tick();
    store(3'b001, 32'h0000_2001, 32'h1234_5678);
    tick();
    bus.st_valid = 1'b0;
    chk("ill_empty",  bus.empty, 1);
    chk("ill_req",    bus.mem_req, 0);
    chk("ill_flag",   bus.misaligned_err, 1);
    chk("ill_cnt2",   bus.err_count, 2);
    store(3'b011, 32'h0000_2000, 32'h1234_5678);
    tick();
    bus.st_valid = 1'b0;
    chk("ill_cnt3",   bus.err_count, 3);
    chk("ill_empty2", bus.empty, 1);

    // Eight SH stores with ready toggling; outputs must hold while stalled
    sent      = 0;
    popped    = 0;
    prev_hold = 1'b0;
    hold_addr = '0;
    hold_be   = '0;
    hold_wdata = '0;
    for (int cyc = 0; cyc < 80 && popped < 8; cyc++) begin
      bus.mem_ready = (cyc % 2 == 0);
      if (sent < 8) begin
        store(3'b001, 32'h400 + 32'(4*sent) + ((sent % 2 == 1) ? 32'd2 : 32'd0),
              32'hFFFF_0000 | (32'hA000 + 32'(sent)));
      end else begin
        bus.st_valid = 1'b0;
      end
      if (prev_hold) begin
        chk("sh_hold_addr",  bus.mem_addr, hold_addr);
        chk("sh_hold_be",    bus.mem_be, hold_be);
        chk("sh_hold_wdata", bus.mem_wdata, hold_wdata);
      end
      accept = bus.st_valid & ~bus.stall;
      if (bus.mem_req && bus.mem_ready) begin
        hw = 16'(32'hA000 + 32'(popped));
        chk("sh_addr",  bus.mem_addr, 32'h400 + 32'(4*popped));
        chk("sh_be",    bus.mem_be, (popped % 2 == 1) ? 4'b1100 : 4'b0011);
        chk("sh_wdata", bus.mem_wdata, {hw, hw});
        popped++;
      end
      prev_hold  = bus.mem_req & ~bus.mem_ready;
      hold_addr  = bus.mem_addr;
      hold_be    = bus.mem_be;
      hold_wdata = bus.mem_wdata;
      tick();
      if (accept) sent++;
    end
    bus.st_valid = 1'b0;
    chk("sh_all_drained", popped, 8);
    chk("sh_all_sent",    sent, 8);

    // Reset in the middle of a cycle with entries pending
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(3'b010, 32'h500 + 32'(4*i), 32'hCAFE_0000 + 32'(i));
      tick();
    end
    bus.st_valid = 1'b0;
    chk("pre_rst_req",   bus.mem_req, 1);
    chk("pre_rst_empty", bus.empty, 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req",    bus.mem_req, 0);
    chk("mid_rst_empty",  bus.empty, 1);
    chk("mid_rst_errcnt", bus.err_count, 0);
    chk("mid_rst_flag",   bus.misaligned_err, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_req",   bus.mem_req, 0);
    chk("post_rst_empty", bus.empty, 1);

    // Two byte stores into the same word
    bus.mem_ready = 1'b0;
    store(3'b000, 32'h300, 32'h11);
    tick();
    store(3'b000, 32'h301, 32'h22);
    tick();
    bus.st_valid = 1'b0;
    chk("pair_addr", bus.mem_addr, 32'h300);
`ifdef STORE_COALESCE_EN
    chk("merge_be",    bus.mem_be, 4'b0011);
    chk("merge_wdata", bus.mem_wdata, 32'h1111_2211);
    bus.mem_ready = 1'b1;
    tick();
    chk("merge_single", bus.empty, 1);
`else
    chk("pair_be0",    bus.mem_be, 4'b0001);
    chk("pair_wdata0", bus.mem_wdata, 32'h1111_1111);
    bus.mem_ready = 1'b1;
    tick();
    chk("pair_addr1",  bus.mem_addr, 32'h300);
    chk("pair_be1",    bus.mem_be, 4'b0010);
    chk("pair_wdata1", bus.mem_wdata, 32'h2222_2222);
    tick();
    chk("pair_empty",  bus.empty, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Memory-side responder for the single-cycle core's store port.
- Accepts each store the core issues (ALU address, store data, store width, write strobe) and converts it to a word-aligned, byte-enabled write.
- Queues the write in a small in-order FIFO and drains it to the data RAM/bus over a req/ready handshake.
- Back-pressures the core with `stall` when full and flags illegal stores.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store strobe from core (mem_write).
- st_addr  in  32  byte address (value_from_alu).
- st_data  in  32  store data (data_to_write).
- st_width  in  3  funct3: 000 SB, 001 SH, 010 SW.
- stall  out  1  FIFO full; the offered store is not accepted.
- mem_req  out  1  head entry valid toward memory.
- mem_ready  in  1  memory accepts head this cycle.
- mem_addr  out  32  word address, bits [1:0] = 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- empty  out  1  no pending stores (used for fence/debug).
- misaligned_err  out  1  sticky illegal-store flag.
- err_count  out  ERR_W  saturating count of dropped stores.

Behaviour:
- Reset (async assert, sync release): pointers = 0, count = 0, mem_req = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, empty = 1, stall = 0, misaligned_err = 0, err_count = 0. Reset mid-drain discards all entries; no partial write survives.
- Legal store:
  - SB: any address.
  - SH: st_addr[0] = 0.
  - SW: st_addr[1:0] = 00.
  - Any other st_width value, or a misaligned address, is illegal.
- Illegal store with st_valid = 1 and stall = 0:
  - Not enqueued.
  - misaligned_err set to 1 (sticky until reset).
  - err_count += 1, saturating at all-ones.
- Lane formatting, with a = st_addr[1:0]:
  - SB: be = 0001 << a; wdata = byte replicated to 4 lanes.
  - SH: be = 0011 (a = 00) or 1100 (a = 10); wdata = halfword replicated to both halves.
  - SW: be = 1111; wdata = st_data.
  - Entry address = {st_addr[31:2], 2'b00}.
- Push condition: st_valid & legal & ~full.
- stall:
  - Equals registered full (count == DEPTH), independent of st_valid.
  - No same-cycle bypass: while full, a push is refused even if a pop occurs that cycle.
  - The core holds its store while stall = 1.
- Drain FSM, two states:
  - IDLE: mem_req = 0. Go to REQ when count != 0.
  - REQ: mem_req = 1; mem_addr/mem_be/mem_wdata driven from the head entry and held stable until mem_ready.
  - On mem_req & mem_ready: pop head. Stay in REQ if entries remain after the pop (including a same-cycle push); otherwise go to IDLE.
- Latency: a store accepted at edge N makes mem_req high in cycle N+1 if the FIFO was empty. Minimum occupancy is 1 cycle when mem_ready is held at 1.
- Throughput: 1 store/cycle sustained with mem_ready = 1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Wrap-around: pointers are log2(DEPTH) bits plus a wrap bit; full/empty derived from them. Order is strictly FIFO.
- empty = (count == 0). It is registered-state derived, not combinational from the inputs.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- When defined: a legal store whose word address equals the tail (youngest) entry is merged into that entry instead of allocating a new slot. Conditions:
  - The tail entry is not the head currently being presented with mem_ready = 1 that cycle.
  - Merge: be |= new_be; lanes in new_be overwrite data.
  - A merge is accepted even when full.
- When undefined: every legal store allocates its own entry, and the coalescing logic is absent.

Test Plan:
- SB, st_addr 0x0000_1003, st_data 0x0000_00AB, mem_ready = 1 -> next cycle mem_req = 1, mem_addr 0x0000_1000, mem_be 1000, mem_wdata 0xABAB_ABAB; empty = 1 one cycle later.
- mem_ready = 0, issue 4 SW to 0x100, 0x104, 0x108, 0x10C -> stall = 1 after the 4th. Hold a 5th SW to 0x110, then set mem_ready = 1 -> writes complete in order 0x100…0x110 and stall drops after the first pop.
- SW to 0x0000_2002, and SH to 0x0000_2001 -> nothing enqueued, misaligned_err = 1, err_count = 2. Separately, st_width = 011 -> err_count increments by 1.
- mem_ready toggled 1,0,1,0 with 8 back-to-back SH stores -> mem_addr/mem_be/mem_wdata stable whenever req & ~ready; all 8 drain in order with correct halfword lanes.
- 3 entries pending, reset_n pulsed low mid-cycle -> mem_req falls immediately, empty = 1, err_count = 0; no pending write emerges after release.
- STORE_COALESCE_EN defined, mem_ready = 0: SB 0x300 = 0x11, then SB 0x301 = 0x22 -> one entry, be 0011, wdata[15:0] = 0x2211; count = 1.
